// File: rtl/pp_pipeline_accel_fifo_wr_arbiter.sv
// Round-robin arbiter that shares one shift-register FIFO write port among NUM_REQ ap_fifo sources.
// Each grant is a bounded burst sized against the FIFO's free space, and data passes through combinationally.
module pp_pipeline_accel_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_empty_n_i,
  output logic [NUM_REQ-1:0]            req_read_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dout_i,
  input  logic                          fifo_full_n_i,
  output logic                          fifo_write_o,
  output logic [DATA_WIDTH-1:0]         fifo_din_o,
  input  logic [ADDR_WIDTH:0]           fifo_num_data_valid_i,
  input  logic [ADDR_WIDTH:0]           fifo_cap_i,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] BURST_LEN_MAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [GW-1:0] GNT_ONE       = GW'(1);
  localparam logic [GW-1:0] GNT_LAST      = GW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e          state_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   grant_id_q;
  logic [CW-1:0]   beat_cnt_q;
  logic [CW-1:0]   burst_len_q;

  logic [CW-1:0]   free;
  logic [CW-1:0]   burst_len_d;
  logic [GW-1:0]   rr_ptr_d;
  logic [GW-1:0]   cand_idx;
  logic [GW-1:0]   pick_idx;
  logic            pick_valid;
  logic            src_avail;
  logic            beat;
  logic            last_beat;

  logic [DATA_WIDTH-1:0] src_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign src_data[i] = req_dout_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign free        = fifo_cap_i - fifo_num_data_valid_i;
  assign burst_len_d = (free < BURST_LEN_MAX) ? free : BURST_LEN_MAX;
  assign rr_ptr_d    = (grant_id_q == GNT_LAST) ? '0 : grant_id_q + GNT_ONE;

  // Scanning from the highest offset down lets the lowest offset from rr_ptr win without a break.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_empty_n_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Reset gates the strobes combinationally so nothing pops or pushes while it is held.
  assign src_avail    = req_empty_n_i[grant_id_q];
  assign beat         = (state_q == BURST) && src_avail && fifo_full_n_i && !reset;
  assign last_beat    = beat && (beat_cnt_q == burst_len_q - CNT_ONE);
  assign req_read_o   = beat ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign fifo_write_o = beat;
  assign fifo_din_o   = src_data[grant_id_q];
  assign grant_id_o   = grant_id_q;
  assign busy_o       = (state_q == BURST);

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid && (free != '0)) begin
            grant_id_q  <= pick_idx;
            burst_len_q <= burst_len_d;
            beat_cnt_q  <= '0;
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + CNT_ONE;
          end
          // A drained source ends the grant even if no beat was ever written.
          if (!src_avail || last_beat) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_wr_arbiter.sv
// Randomized bench for the FIFO write arbiter: source/FIFO models drive the DUT, and a transaction-level
// reference model predicts grants and writes while a scoreboard checks the data order for each source.
module tb_pp_pipeline_accel_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int AW  = 3;
  localparam int BM  = 4;
  localparam int CAP = 7;

  logic               clk;
  logic               reset;
  logic [N-1:0]       req_empty_n;
  logic [N-1:0]       req_read;
  logic [N*DW-1:0]    req_dout;
  logic               fifo_full_n;
  logic               fifo_write;
  logic [DW-1:0]      fifo_din;
  logic [AW:0]        fifo_num_data_valid;
  logic [AW:0]        fifo_cap;
  logic [1:0]         grant_id;
  logic               busy;

  pp_pipeline_accel_fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(BM)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_empty_n_i         (req_empty_n),
    .req_read_o            (req_read),
    .req_dout_i            (req_dout),
    .fifo_full_n_i         (fifo_full_n),
    .fifo_write_o          (fifo_write),
    .fifo_din_o            (fifo_din),
    .fifo_num_data_valid_i (fifo_num_data_valid),
    .fifo_cap_i            (fifo_cap),
    .grant_id_o            (grant_id),
    .busy_o                (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed;
  int total;
  int wr_count;

  logic [DW-1:0] src_q [N][$];
  logic [DW-1:0] exp_q [N][$];

  int occ;
  int drain_pct;
  bit force_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_empty_n[i] = (src_q[i].size() != 0);
      req_dout[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
    fifo_num_data_valid = (AW+1)'(occ);
    fifo_full_n = (occ < CAP) && !force_full;
  endtask

  // One clock: sample strobes before the edge, then apply pops, pushes and drain after it.
  task automatic tick();
    logic [N-1:0] rd;
    logic         wr;
    @(negedge clk);
    rd = req_read;
    wr = fifo_write;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rd[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    if (wr) occ++;
    if (occ > 0 && int'($urandom_range(0, 99)) < drain_pct) occ--;
    drive();
  endtask

  task automatic push_beat(input int i);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    src_q[i].push_back(d);
    exp_q[i].push_back(d);
    drive();
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 64'(pending()), 64'd0);
    repeat (3) tick();
  endtask

  // Reference model: each grant is a burst record with a beat budget; data comes from the scoreboard.
  int  m_rr;
  int  m_gnt;
  int  m_left;
  bit  m_busy;

  initial begin
    logic [AW:0] free;
    bit          exp_beat;
    m_rr = 0; m_gnt = 0; m_left = 0; m_busy = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("busy", 64'(busy), 64'(m_busy));
      check("grant_id", 64'(grant_id), 64'(m_gnt));
      exp_beat = !reset && m_busy && req_empty_n[m_gnt] && fifo_full_n;
      check("fifo_write", 64'(fifo_write), 64'(exp_beat));
      check("req_read", 64'(req_read), exp_beat ? (64'd1 << m_gnt) : 64'd0);
      if (fifo_write) wr_count++;
      if (exp_beat) begin
        if (exp_q[m_gnt].size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else check("fifo_din", fifo_din, exp_q[m_gnt].pop_front());
      end
      if (reset) begin
        m_busy = 0; m_rr = 0; m_gnt = 0;
      end else if (!m_busy) begin
        free = fifo_cap - fifo_num_data_valid;
        if (free != 0) begin
          for (int k = 0; k < N; k++) begin
            if (req_empty_n[(m_rr + k) % N]) begin
              m_gnt  = (m_rr + k) % N;
              m_left = (int'(free) < BM) ? int'(free) : BM;
              m_busy = 1;
              break;
            end
          end
        end
      end else if (!req_empty_n[m_gnt]) begin
        m_busy = 0;
        m_rr   = (m_gnt + 1) % N;
      end else if (exp_beat) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_rr   = (m_gnt + 1) % N;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wr0;
    int wr1;
    int n;
    passed = 0; total = 0; wr_count = 0;
    occ = 0; drain_pct = 100; force_full = 0;
    fifo_cap = (AW+1)'(CAP);
    reset = 1'b1;
    drive();
    repeat (3) tick();
    reset = 1'b0;
    drive();

    // All sources empty: the model expects no activity for 20 cycles.
    wr0 = wr_count;
    repeat (20) tick();
    check("idle_writes", 64'(wr_count - wr0), 64'd0);

    // Single source with 10 beats: bursts of BURST_MAX with a bubble, order preserved.
    for (int j = 0; j < 10; j++) push_beat(2);
    run_until_empty("single_src", 100);

    // All sources loaded, FIFO drained every cycle: full rotation of 4-beat grants.
    for (int j = 0; j < 12; j++)
      for (int i = 0; i < N; i++) push_beat(i);
    run_until_empty("all_src", 300);

    // Occupancy 5 of 7: exactly two writes, then no grant until space frees up.
    drain_pct = 0;
    occ = 5;
    drive();
    wr0 = wr_count;
    for (int j = 0; j < 10; j++) push_beat(0);
    repeat (12) tick();
    check("low_free_writes", 64'(wr_count - wr0), 64'd2);
    drain_pct = 100;
    run_until_empty("low_free", 200);

    // Full for 3 cycles mid-burst: stall with no writes, then resume intact.
    wr0 = wr_count;
    for (int j = 0; j < 8; j++) push_beat(3);
    n = 0;
    while (wr_count == wr0 && n < 20) begin tick(); n++; end
    check("stall_first_beat", 64'(wr_count > wr0), 64'd1);
    force_full = 1;
    drive();
    wr1 = wr_count;
    repeat (3) tick();
    check("stall_writes", 64'(wr_count - wr1), 64'd0);
    force_full = 0;
    drive();
    run_until_empty("stall", 100);
    check("stall_total", 64'(wr_count - wr0), 64'd8);

    // Reset after two beats of a src1 burst: next grant goes to src0.
    wr0 = wr_count;
    for (int j = 0; j < 8; j++) push_beat(1);
    n = 0;
    while (wr_count - wr0 < 2 && n < 20) begin tick(); n++; end
    check("rst_two_beats", 64'(wr_count - wr0), 64'd2);
    reset = 1'b1;
    drive();
    for (int j = 0; j < 4; j++) push_beat(0);
    wr1 = wr_count;
    repeat (2) tick();
    check("rst_writes", 64'(wr_count - wr1), 64'd0);
    reset = 1'b0;
    drive();
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    check("rst_next_busy", 64'(busy), 64'd1);
    check("rst_next_grant", 64'(grant_id), 64'd0);
    run_until_empty("rst", 100);

    // Random traffic with random drain and back-pressure.
    drain_pct = 60;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 35) push_beat(int'($urandom_range(0, N-1)));
      force_full = ($urandom_range(0, 99) < 10);
      drive();
      tick();
    end
    force_full = 0;
    drain_pct = 100;
    drive();
    run_until_empty("random", 2000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
